// File: rtl/dac_multi.sv
// dac_multi: SPI sequencer for the AD5628/AD5648/AD5668. After reset, the first update sends an internal-reference setup frame, then one frame per channel.
// Define DAC_MULTI_LDAC_EN to add an ldac output. All channel frames then use command 0, and one ldac pulse updates all channels together.
module dac_multi #(
  parameter int NCH     = 2,
  parameter int DW      = 12,
  parameter int CLKDIV  = 1,
  parameter int CSN_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] din,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              csn,
  output logic              mosi,
  output logic              sclk
`ifdef DAC_MULTI_LDAC_EN
  ,
  output logic              ldac
`endif
);

  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int GW = (CSN_GAP > 1) ? $clog2(CSN_GAP) : 1;
  localparam logic [2:0] LAST = 3'(NCH - 1);
`ifdef DAC_MULTI_LDAC_EN
  localparam logic [3:0] CMD_LAST = 4'h0;
`else
  localparam logic [3:0] CMD_LAST = 4'h2;
`endif

  // state | meaning
  // IDLE  | waiting for start, csn high
  // LOAD  | first cycle of a frame: csn low, bit 31 on mosi
  // SHIFT | clocking out the remaining frame bits
  // GAP   | csn held high between frames
  // LDAC  | ldac held low for two cycles (optional build)
  // DONE  | one-cycle done pulse, then IDLE
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
`ifdef DAC_MULTI_LDAC_EN
    LDAC  = 3'd5,
`endif
    DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [NCH*DW-1:0] hold;
  logic [30:0]       sh;
  logic [4:0]        bitn;
  logic [CW-1:0]     cnt;
  logic [GW-1:0]     gcnt;
  logic [2:0]        ch;
  logic              cur_setup;
  logic              ref_done;
`ifdef DAC_MULTI_LDAC_EN
  logic              lcnt;
`endif

  logic              nf_setup;
  logic [2:0]        nf_ch;
  logic [NCH*DW-1:0] nf_src;
  logic [31:0]       nf;
  logic              go;

  function automatic logic [31:0] frame_for(input logic setup, input logic [2:0] c,
                                            input logic [NCH*DW-1:0] src);
    logic [DW-1:0] d;
    logic [15:0]   f;
    logic [3:0]    cmd;
    d   = src[int'(c)*DW +: DW];
    f   = 16'(d) << (16 - DW);
    cmd = (c == LAST) ? CMD_LAST : 4'h0;
    frame_for = setup ? 32'h0800_0001 : {4'h0, cmd, 1'b0, c, f, 4'h0};
  endfunction

  // The first frame of a sequence is built straight from din, so csn can fall on the cycle after start.
  always_comb begin
    nf_setup = 1'b0;
    nf_ch    = 3'd0;
    nf_src   = hold;
    go       = 1'b0;
    if (state == IDLE) begin
      nf_setup = ~ref_done;
      nf_src   = din;
      go       = start;
    end else begin
      if (!cur_setup) nf_ch = ch + 3'd1;
      go = (state == GAP) && (gcnt == '0) && (cur_setup || ch != LAST);
    end
    nf = frame_for(nf_setup, nf_ch, nf_src);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      csn       <= 1'b1;
      sclk      <= 1'b1;
      mosi      <= 1'b0;
      ref_done  <= 1'b0;
      cur_setup <= 1'b0;
      ch        <= 3'd0;
      hold      <= '0;
      sh        <= '0;
      bitn      <= 5'd0;
      cnt       <= '0;
      gcnt      <= '0;
`ifdef DAC_MULTI_LDAC_EN
      ldac      <= 1'b1;
      lcnt      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          hold <= din;
        end
        LOAD, SHIFT: begin
          state <= SHIFT;
          if (cnt != '0) cnt <= cnt - CW'(1);
          else begin
            cnt <= CW'(CLKDIV - 1);
            if (sclk) sclk <= 1'b0;
            else if (bitn == 5'd0) begin
              csn   <= 1'b1;
              sclk  <= 1'b1;
              mosi  <= 1'b0;
              gcnt  <= GW'(CSN_GAP - 1);
              state <= GAP;
              if (cur_setup) ref_done <= 1'b1;
            end else begin
              sclk <= 1'b1;
              mosi <= sh[30];
              sh   <= {sh[29:0], 1'b0};
              bitn <= bitn - 5'd1;
            end
          end
        end
        GAP: begin
          if (gcnt != '0) gcnt <= gcnt - GW'(1);
          else if (!go) begin
`ifdef DAC_MULTI_LDAC_EN
            ldac  <= 1'b0;
            lcnt  <= 1'b1;
            state <= LDAC;
`else
            done  <= 1'b1;
            state <= DONE;
`endif
          end
        end
`ifdef DAC_MULTI_LDAC_EN
        LDAC: begin
          if (lcnt) lcnt <= 1'b0;
          else begin
            ldac  <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end
        end
`endif
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (go) begin
        state     <= LOAD;
        csn       <= 1'b0;
        sclk      <= 1'b1;
        mosi      <= nf[31];
        sh        <= nf[30:0];
        bitn      <= 5'd31;
        cnt       <= CW'(CLKDIV - 1);
        ch        <= nf_ch;
        cur_setup <= nf_setup;
      end
    end
  end

endmodule
